pic_usart_async: RTL

//  Simplified PIC16F628A-style asynchronous USART peripheral. It is always bound to the dedicated

---
 rtl/pic_usart_async.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pic_usart_async.sv
// PIC16F628A-style asynchronous USART: 8N1 framing, 16x oversampling, TXREG buffer + TSR shifter,
// and a small receive FIFO that models RCREG. uart_rx is asynchronous to clk.
module pic_usart_async #(
  parameter int RX_SYNC_STAGES = 2,
  parameter int RX_FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       txreg_wr_en,
  input  logic       txsta_wr_en,
  input  logic       rcsta_wr_en,
  input  logic       spbrg_wr_en,
  input  logic       rcreg_rd_en,
  output logic [7:0] txsta,
  output logic [7:0] rcsta,
  output logic [7:0] spbrg,
  output logic [7:0] rcreg,
  output logic       txif,
  output logic       rcif,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic       spen_q, spen_d, cren_q, cren_d, txen_q, txen_d, oerr_q, oerr_d;
  logic [7:0] spbrg_q, spbrg_d, brg_cnt_q, brg_cnt_d;
  logic       tick16;

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tsr_q, tsr_d, txbuf_q, txbuf_d;
  logic       txbuf_full_q, txbuf_full_d, tx_load, tx_ok;

  logic [RX_SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic       rx_in, rx_prev_q, rx_prev_d, rx_abort, rx_push;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [8:0] rx_push_data;

  logic [8:0]  fifo_q [RX_FIFO_DEPTH];
  logic [8:0]  fifo_d [RX_FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, fifo_pop, push_ok;
  logic [8:0]  fifo_head;

  // Control registers and the shared baud generator (held in reload while SPEN=0)
  always_comb begin
    spen_d    = spen_q;
    cren_d    = cren_q;
    txen_d    = txen_q;
    spbrg_d   = spbrg_q;
    brg_cnt_d = brg_cnt_q - 8'd1;
    if (txsta_wr_en) txen_d = data_in[5];
    if (rcsta_wr_en) begin
      spen_d = data_in[7];
      cren_d = data_in[4];
    end
    if (spbrg_wr_en) spbrg_d = data_in;
    if (spbrg_wr_en)                         brg_cnt_d = data_in;
    else if (!spen_q || brg_cnt_q == 8'd0)   brg_cnt_d = spbrg_q;
  end

  assign tick16 = spen_q && (brg_cnt_q == 8'd0);
  assign tx_ok  = spen_q && txen_q;

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_tick_d    = tx_tick_q;
    tx_bit_d     = tx_bit_q;
    tsr_d        = tsr_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    tx_load      = 1'b0;
    if (txreg_wr_en && !txbuf_full_q) begin
      txbuf_d      = data_in;
      txbuf_full_d = 1'b1;
    end
    case (tx_state_q)
      TX_IDLE:  tx_load = txbuf_full_q;
      TX_START: if (tick16) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: if (tick16) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tsr_d    = {1'b0, tsr_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: if (tick16) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_state_d = TX_IDLE;
          tx_load    = txbuf_full_q;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // A pending buffer enters the shifter straight from STOP, so frames run back-to-back
    if (tx_load) begin
      tsr_d        = txbuf_q;
      txbuf_full_d = 1'b0;
      tx_state_d   = TX_START;
      tx_tick_d    = 4'd0;
    end
    if (!tx_ok) begin
      tx_state_d   = TX_IDLE;
      tx_tick_d    = 4'd0;
      txbuf_full_d = 1'b0;
    end
  end

  assign rx_sync_d = {rx_sync_q[RX_SYNC_STAGES-2:0], uart_rx};
  assign rx_in     = rx_sync_q[RX_SYNC_STAGES-1];
  assign rx_prev_d = rx_in;
  assign rx_abort  = !(spen_q && cren_q) || (rcsta_wr_en && !(data_in[7] && data_in[4]));

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_push_data = {1'b0, rx_shift_q};
    case (rx_state_q)
      RX_IDLE: if (!oerr_q && rx_prev_q && !rx_in) begin
        rx_state_d = RX_START;
        rx_tick_d  = 4'd0;
      end
      RX_START: if (tick16) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd7) begin
          rx_state_d = rx_in ? RX_IDLE : RX_DATA;
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: if (tick16) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: if (tick16) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_push      = 1'b1;
          rx_push_data = {!rx_in, rx_shift_q};
          rx_state_d   = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_abort) begin
      rx_state_d = RX_IDLE;
      rx_tick_d  = 4'd0;
      rx_push    = 1'b0;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = rcreg_rd_en && !fifo_empty;
  assign push_ok    = rx_push && (!fifo_full || fifo_pop);
  assign fifo_head  = fifo_q[rd_ptr_q[AW-1:0]];

  // Pop frees the head slot first, so a simultaneous push into a full FIFO still fits
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    oerr_d   = oerr_q;
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok) begin
      fifo_d[wr_ptr_q[AW-1:0]] = rx_push_data;
      wr_ptr_d                 = wr_ptr_q + PTR_ONE;
    end
    if (rx_push && !push_ok) oerr_d = 1'b1;
    if (rcsta_wr_en && !data_in[4]) oerr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spen_q       <= 1'b0;
      cren_q       <= 1'b0;
      txen_q       <= 1'b0;
      oerr_q       <= 1'b0;
      spbrg_q      <= 8'h00;
      brg_cnt_q    <= 8'h00;
      tx_state_q   <= TX_IDLE;
      tx_tick_q    <= 4'd0;
      tx_bit_q     <= 3'd0;
      tsr_q        <= 8'h00;
      txbuf_q      <= 8'h00;
      txbuf_full_q <= 1'b0;
      rx_sync_q    <= '1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= 4'd0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      spen_q       <= spen_d;
      cren_q       <= cren_d;
      txen_q       <= txen_d;
      oerr_q       <= oerr_d;
      spbrg_q      <= spbrg_d;
      brg_cnt_q    <= brg_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tsr_q        <= tsr_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign uart_tx = (tx_state_q == TX_START) ? 1'b0 :
                   (tx_state_q == TX_DATA)  ? tsr_q[0] : 1'b1;
  assign txif  = !txbuf_full_q;
  assign rcif  = !fifo_empty;
  assign txsta = {2'b00, txen_q, 3'b000, (tx_state_q == TX_IDLE), 1'b0};
  assign rcsta = {spen_q, 2'b00, cren_q, 1'b0, (!fifo_empty && fifo_head[8]), oerr_q, 1'b0};
  assign spbrg = spbrg_q;
  assign rcreg = fifo_empty ? 8'h00 : fifo_head[7:0];

endmodule
